// File: rtl/sprite_renderer.sv
// sprite_renderer: scanline sprite engine; fetches one bitmap row per line and shifts it out on gfx.
// Define SPRITE_RENDERER_MIRROR_EN to add the hmirror input (LSB drawn leftmost when set).
module sprite_renderer #(
   parameter int SPRITE_W  = 8,
   parameter int SPRITE_H  = 8,
   parameter int H_DISPLAY = 640,
   localparam int ROW_W    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [15:0]         hpos,
   input  logic [15:0]         vpos,
   input  logic                hsync,
   input  logic [15:0]         sprite_x,
   input  logic [15:0]         sprite_y,
`ifdef SPRITE_RENDERER_MIRROR_EN
   input  logic                hmirror,
`endif
   output logic [ROW_W-1:0]    rom_addr,
   input  logic [SPRITE_W-1:0] rom_bits,
   output logic                gfx,
   output logic                in_progress
);

   localparam int PIX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SPRITE_H - 1);
   localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(SPRITE_W - 1);
   localparam logic [16:0]      H_LIMIT  = 17'(H_DISPLAY);

   typedef enum logic [2:0] {
      IDLE, WAIT_LOAD, LOAD_SETUP, LOAD_FETCH, WAIT_HSTART, DRAW, WAIT_END
   } state_t;

   state_t              state_q, state_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [PIX_W-1:0]    pix_q, pix_d;
   logic [SPRITE_W-1:0] shift_q, shift_d;
   logic                gfx_q, gfx_d;
   logic                hsync_q;
   logic                load_edge;
   logic                hstart;
   logic [SPRITE_W-1:0] fetch_bits;

`ifdef SPRITE_RENDERER_MIRROR_EN
   logic [SPRITE_W-1:0] bits_rev;
   for (genvar gi = 0; gi < SPRITE_W; gi++) begin : g_rev
      assign bits_rev[gi] = rom_bits[SPRITE_W-1-gi];
   end
   assign fetch_bits = hmirror ? bits_rev : rom_bits;
`else
   assign fetch_bits = rom_bits;
`endif

   assign load_edge   = hsync_q & ~hsync;
   // sprite_x is compared live; off-screen columns never start a draw.
   assign hstart      = (hpos == sprite_x) && ({1'b0, sprite_x} < H_LIMIT);
   assign rom_addr    = row_q;
   assign gfx         = gfx_q;
   assign in_progress = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         row_q   <= '0;
         pix_q   <= '0;
         shift_q <= '0;
         gfx_q   <= 1'b0;
         hsync_q <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         pix_q   <= pix_d;
         shift_q <= shift_d;
         gfx_q   <= gfx_d;
         hsync_q <= hsync;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      pix_d   = pix_q;
      shift_d = shift_q;
      gfx_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (vpos == sprite_y && hpos == 16'd0) begin
               row_d   = '0;
               state_d = WAIT_LOAD;
            end
         end
         WAIT_LOAD: begin
            if (load_edge) state_d = LOAD_SETUP;
         end
         LOAD_SETUP: state_d = LOAD_FETCH;
         LOAD_FETCH: begin
            shift_d = fetch_bits;
            state_d = WAIT_HSTART;
         end
         WAIT_HSTART: begin
            // A new line began before the start column was seen: drop this row.
            if (load_edge) begin
               if (row_q == LAST_ROW) begin
                  state_d = IDLE;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = LOAD_SETUP;
               end
            end else if (hstart) begin
               gfx_d   = shift_q[SPRITE_W-1];
               shift_d = shift_q << 1;
               pix_d   = '0;
               state_d = DRAW;
            end
         end
         DRAW: begin
            if (pix_q == LAST_PIX) begin
               state_d = WAIT_END;
            end else begin
               gfx_d   = shift_q[SPRITE_W-1];
               shift_d = shift_q << 1;
               pix_d   = pix_q + 1'b1;
            end
         end
         WAIT_END: begin
            if (row_q == LAST_ROW) begin
               state_d = IDLE;
            end else begin
               row_d   = row_q + 1'b1;
               state_d = WAIT_LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
